seq_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider: the inverse arithmetic path to
//   the adder chain, built on a trial subtraction with borrow each cycle.

---
 rtl/seq_divider.sv | 115 +++++++++++
 tb/tb_seq_divider.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per
// clock, with a START/DONE handshake.
//
// Ports
//   CLK       in   1      rising-edge clock
//   RST       in   1      asynchronous reset, active low
//   START     in   1      divide request, sampled only in IDLE
//   DVND      in   WIDTH  dividend, captured on the accepting edge
//   DVSR      in   WIDTH  divisor, captured on the accepting edge
//   QUOT      out  WIDTH  quotient, updated on completion and then held
//   REM       out  WIDTH  remainder, updated on completion and then held
//   BUSY      out  1      high while iterating
//   DONE      out  1      one-cycle completion pulse
//   DIV_ZERO  out  1      last completed divide had a zero divisor
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for START; results from the last divide are held
// ST_RUN  | one restoring step per edge, cnt counts down to 0
// ST_DONE | results just updated, DONE asserted for this cycle only
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] DVND,
  input  logic [WIDTH-1:0] DVSR,
  output logic [WIDTH-1:0] QUOT,
  output logic [WIDTH-1:0] REM,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_ZERO
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] p;      // partial remainder; always < divisor, so the top bit is implicit 0
  logic [WIDTH-1:0] q;      // dividend shifting out the top, quotient bits shifting in
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_next;

  // One restoring step: shift the next dividend bit into P, trial-subtract.
  always_comb begin
    p_shift = {p, q[WIDTH-1]};
    diff    = p_shift - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      p_next = diff[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      p_next = p_shift[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

  assign BUSY = (state == ST_RUN);
  assign DONE = (state == ST_DONE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      divisor  <= '0;
      p        <= '0;
      q        <= '0;
      QUOT     <= '0;
      REM      <= '0;
      DIV_ZERO <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            divisor <= DVSR;
            p       <= '0;
            q       <= DVND;
            if (DVSR == '0) begin
              // No iteration for a zero divisor: publish the fixed result now.
              QUOT     <= '1;
              REM      <= DVND;
              DIV_ZERO <= 1'b1;
              state    <= ST_DONE;
            end else begin
              cnt   <= CW'(WIDTH - 1);
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          p <= p_next;
          q <= q_next;
          if (cnt == '0) begin
            QUOT     <= q_next;
            REM      <= p_next;
            DIV_ZERO <= 1'b0;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): directed table, handshake
// corner cases, and random operands against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [W-1:0] DVND, DVSR;
  logic [W-1:0] QUOT, REM;
  logic         BUSY, DONE, DIV_ZERO;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DVND(DVND), .DVSR(DVSR),
    .QUOT(QUOT), .REM(REM), .BUSY(BUSY), .DONE(DONE), .DIV_ZERO(DIV_ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one divide; returns at the negedge where DONE was seen (or the
  // budget ran out). inject_at >= 0 pulses START with 7/2 during the run.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int inject_at,
                        output int busy_cycles, output bit got_done);
    @(negedge CLK);
    START = 1'b1; DVND = a; DVSR = b;
    @(posedge CLK);
    #1;
    START = 1'b0; DVND = $urandom; DVSR = $urandom;
    busy_cycles = 0;
    got_done = 1'b0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      @(negedge CLK);
      if (i == inject_at + 1) START = 1'b0;
      if (DONE) got_done = 1'b1;
      else begin
        if (BUSY) busy_cycles++;
        if (i == inject_at) begin
          START = 1'b1; DVND = 32'd7; DVSR = 32'd2;
        end
      end
    end
    START = 1'b0;
  endtask

  task automatic check_result(input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                              input int busy_cycles, input bit got_done);
    chk("done_seen", {63'd0, got_done}, 64'd1);
    chk("busy_cycles", 64'(busy_cycles), edz ? 64'd0 : 64'(W));
    chk("quot", {32'd0, QUOT}, {32'd0, eq});
    chk("rem", {32'd0, REM}, {32'd0, er});
    chk("div_zero", {63'd0, DIV_ZERO}, {63'd0, edz});
    @(negedge CLK);
    chk("done_one_cycle", {62'd0, DONE, BUSY}, 64'd0);
    chk("quot_held", {32'd0, QUOT}, {32'd0, eq});
    chk("rem_held", {32'd0, REM}, {32'd0, er});
  endtask

  vec_t vecs[8];

  initial begin
    int bc;
    bit gd;
    logic [W-1:0] a, b, eq, er;
    int gap;
    bit seen;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,    1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,    1'b0};
    vecs[2] = '{32'd5,          32'd9,          32'd0,          32'd5,    1'b0};
    vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,    1'b0};
    vecs[4] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,    1'b0};
    vecs[5] = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234, 1'b1};
    vecs[6] = '{32'd10,         32'd3,          32'd3,          32'd1,    1'b0};
    vecs[7] = '{32'd0,          32'd5,          32'd0,          32'd0,    1'b0};

    RST = 1'b0; START = 1'b0; DVND = '0; DVSR = '0;
    #12;
    chk("reset_outputs", {QUOT, REM}, 64'd0);
    chk("reset_flags", {61'd0, BUSY, DONE, DIV_ZERO}, 64'd0);
    @(negedge CLK);
    RST = 1'b1;

    foreach (vecs[i]) begin
      do_div(vecs[i].a, vecs[i].b, -1, bc, gd);
      check_result(vecs[i].q, vecs[i].r, vecs[i].dz, bc, gd);
    end

    // START during RUN is ignored: 100/7 still yields 14 r 2.
    do_div(32'd100, 32'd7, 10, bc, gd);
    check_result(32'd14, 32'd2, 1'b0, bc, gd);
    @(negedge CLK);
    chk("no_queued_start", {63'd0, BUSY}, 64'd0);

    // START held high: one result every W+2 cycles.
    @(negedge CLK);
    START = 1'b1; DVND = 32'd100; DVSR = 32'd7;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
    chk("b2b_first_done", {63'd0, seen}, 64'd1);
    gap = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      gap++;
      if (DONE) seen = 1'b1;
    end
    START = 1'b0;
    chk("b2b_period", 64'(gap), 64'(W + 2));
    chk("b2b_quot", {QUOT, REM}, {32'd14, 32'd2});
    @(negedge CLK);

    // Async reset mid-divide clears everything at once; result is discarded.
    @(negedge CLK);
    START = 1'b1; DVND = 32'd100; DVSR = 32'd7;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (16) @(negedge CLK);
    chk("pre_reset_busy", {63'd0, BUSY}, 64'd1);
    #2 RST = 1'b0;
    #1;
    chk("async_reset_outputs", {QUOT, REM}, 64'd0);
    chk("async_reset_flags", {61'd0, BUSY, DONE, DIV_ZERO}, 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_after_reset", {62'd0, BUSY, DONE}, 64'd0);
    do_div(32'd9, 32'd4, -1, bc, gd);
    check_result(32'd2, 32'd1, 1'b0, bc, gd);

    // Random operands against plain arithmetic.
    for (int k = 0; k < 1000; k++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom >> $urandom_range(0, 31);
        2: b = $urandom_range(0, 3) == 0 ? 32'd0 : 32'($urandom_range(1, 16));
        3: b = a >> $urandom_range(0, 31);
        default: b = a + 32'($urandom_range(0, 2));
      endcase
      if (b == '0) begin
        eq = '1; er = a;
      end else begin
        eq = a / b; er = a % b;
      end
      do_div(a, b, -1, bc, gd);
      if (b != '0) begin
        chk("invariant", ({32'd0, QUOT} * {32'd0, b}) + {32'd0, REM}, {32'd0, a});
        chk("rem_lt_divisor", {63'd0, (REM < b)}, 64'd1);
      end
      check_result(eq, er, (b == '0), bc, gd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
